// File: rtl/down_counter.sv
// down_counter: loadable down-counter with one-cycle terminal-count pulse; DOWN_COUNTER_RELOAD_EN selects auto-reload over one-shot
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             zero
);
`ifdef DOWN_COUNTER_RELOAD_EN
  localparam bit auto_reload = 1'b1;
`else
  localparam bit auto_reload = 1'b0;
`endif
  localparam logic [WIDTH-1:0] one = 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] reload;
  logic run_en, expire;
  assign run_en = state == RUN && enable;
  assign expire = run_en && Q == one;
  assign zero = Q == '0;
  always_ff @(posedge CLK)
    if (reset) begin
      Q <= '0;
      reload <= '0;
      tc <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      state <= IDLE;
    end else if (load) begin
      Q <= Din;
      reload <= Din;
      tc <= 1'b0;
      busy <= Din != '0;
      done <= Din == '0;
      state <= Din != '0 ? RUN : DONE;
    end else begin
      tc <= expire;
      if (expire) begin
        Q <= auto_reload ? reload : '0;
        state <= auto_reload ? RUN : DONE;
        busy <= auto_reload;
        done <= !auto_reload;
      end else if (run_en)
        Q <= Q - one;
    end
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed self-checking bench for down_counter; honours DOWN_COUNTER_RELOAD_EN
module tb_down_counter;
  logic CLK = 1'b0, reset, load, enable, tc, busy, done, zero;
  logic [3:0] Din, Q;
  int checks = 0, errors = 0, pulses;
  down_counter #(.WIDTH(4)) dut (
    .CLK(CLK), .reset(reset), .load(load), .enable(enable), .Din(Din),
    .Q(Q), .tc(tc), .busy(busy), .done(done), .zero(zero)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input logic r, input logic l, input logic e, input logic [3:0] d);
    reset = r;
    load = l;
    enable = e;
    Din = d;
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic ex(input string tag, input int q, input bit t, input bit b, input bit d);
    chk({tag, ".Q"}, 32'(Q), q);
    chk({tag, ".tc"}, 32'(tc), 32'(t));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".zero"}, 32'(zero), 32'(q == 0));
  endtask
  initial begin
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    ex("reset", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 0);
      ex("idle_hold", 0, 0, 0, 0);
    end
    tick(0, 1, 1, 5);
    ex("load5", 5, 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(0, 0, 1, 0);
`ifdef DOWN_COUNTER_RELOAD_EN
      ex("count5", i == 5 ? 5 : 5 - i, i == 5, 1, 0);
`else
      ex("count5", 5 - i, i == 5, i < 5, i == 5);
`endif
    end
`ifndef DOWN_COUNTER_RELOAD_EN
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1, 0);
      ex("done_hold", 0, 0, 0, 1);
    end
`endif
    tick(0, 1, 0, 3);
    ex("load3", 3, 0, 1, 0);
    tick(0, 0, 1, 0);
    ex("pause1", 2, 0, 1, 0);
    tick(0, 0, 0, 0);
    ex("pause2", 2, 0, 1, 0);
    tick(0, 0, 0, 0);
    ex("pause3", 2, 0, 1, 0);
    tick(0, 0, 1, 0);
    ex("pause4", 1, 0, 1, 0);
    tick(0, 0, 1, 0);
`ifdef DOWN_COUNTER_RELOAD_EN
    ex("pause5", 3, 1, 1, 0);
    tick(0, 1, 0, 3);
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(0, 0, 1, 0);
      ex("reload3", i % 3 == 0 ? 3 : 3 - i % 3, i % 3 == 0, 1, 0);
      pulses += int'(tc);
    end
    chk("reload_pulses", pulses, 4);
    tick(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0);
      ex("reload1", 1, 1, 1, 0);
    end
`else
    ex("pause5", 0, 1, 0, 1);
`endif
    tick(0, 1, 0, 2);
    tick(0, 0, 1, 0);
    ex("pre_coll", 1, 0, 1, 0);
    tick(0, 1, 1, 9);
    ex("load_on_expiry", 9, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 0);
    ex("at4", 4, 0, 1, 0);
    tick(1, 0, 1, 0);
    ex("reset_mid", 0, 0, 0, 0);
    tick(0, 1, 0, 2);
    tick(0, 0, 1, 0);
    tick(1, 0, 1, 0);
    ex("reset_on_expiry", 0, 0, 0, 0);
    tick(0, 1, 1, 0);
    ex("load0", 0, 0, 0, 1);
    tick(0, 0, 1, 0);
    ex("load0_hold", 0, 0, 0, 1);
    tick(0, 1, 0, 15);
    ex("load15", 15, 0, 1, 0);
    for (int i = 1; i <= 15; i++) begin
      tick(0, 0, 1, 0);
`ifdef DOWN_COUNTER_RELOAD_EN
      ex("count15", i == 15 ? 15 : 15 - i, i == 15, 1, 0);
`else
      ex("count15", 15 - i, i == 15, i < 15, i == 15);
`endif
    end
    tick(0, 0, 1, 0);
    chk("tc_falls", 32'(tc), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/down_counter.md
# down_counter

Loadable down-counter with terminal-count signalling: the complement of the team's 4-bit up-counter. It is used as an interval timer and delay generator. A value is loaded on `Din` and decremented on each enabled clock. When the count reaches zero, the block raises a one-cycle `tc` pulse, then either stops or reloads, depending on a compile-time option. It sits beside the up-counter in the timing/control path and drives the sequencing FSMs.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range is 2..16.
- `CLK` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `load` input 1: capture `Din` into `Q` and into the reload register.
- `enable` input 1: decrement qualifier while running; low = pause.
- `Din` input WIDTH: load value, unsigned.
- `Q` output WIDTH: current count, registered.
- `tc` output 1: terminal-count pulse, registered, one cycle wide.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE.
- `zero` output 1: combinational `Q == 0`.

## Operation
- States:
  - IDLE: entered after reset.
  - RUN: counting.
  - DONE: expired; stops until the next `load`.
- Priority per edge: `reset` > `load` > `enable` decrement.
- `reset`:
  - Sets `Q`=0 and reload register=0.
  - Sets `tc`=0 and state=IDLE.
  - Resulting outputs: `busy`=0, `done`=0, `zero`=1.
- `load`, accepted in any state, including mid-count and the `tc` cycle:
  - `Q`←`Din` and reload←`Din`.
  - `Din`≠0 → RUN; `Din`=0 → DONE with no `tc`.
  - `load` cancels any pending expiry.
- RUN with `enable`=1 and `Q`>1: `Q`←`Q`−1.
- RUN with `enable`=1 and `Q`==1 (expiry):
  - Next-cycle `tc`=1.
  - Then follow the Configuration behaviour.
- RUN with `enable`=0: `Q` holds; no `tc`.
- IDLE and DONE ignore `enable`; `Q` holds.
- Arithmetic is unsigned modulo 2^WIDTH, but `Q` never decrements below 0. The wrap from 0 to all-ones is unreachable.
- Maximum load of 2^WIDTH−1 gives 2^WIDTH−1 enabled cycles to expiry.

## Timing
- All outputs except `zero` are registered. `zero` follows `Q` combinationally.
- `load` at edge k → `Q`=`Din` and `busy`=1 visible after edge k.
- A load value N with `enable` held high → `tc` is visible after edge k+N.
- `tc` is high for exactly one cycle per expiry.
- Enabled cycles only count toward N; pauses extend the latency one-for-one.
- `tc` falls on the next edge unless another expiry occurs. This is possible only with reload and N=1.
- `reset` asserted mid-count clears everything on that edge; a pending `tc` is suppressed.
- `load` together with expiry: the load wins, `tc` stays 0, and `Q`=`Din`.

## Configuration
- Macro: `DOWN_COUNTER_RELOAD_EN`.
- Defined (auto-reload):
  - On expiry, `Q`←reload register and the state stays RUN.
  - `tc` pulses; `done` is never asserted.
  - Produces a periodic `tc` every N enabled cycles.
  - With N=1, `tc` stays high continuously while `enable`=1.
- Undefined (one-shot):
  - On expiry, `Q`←0 and state→DONE.
  - `tc` pulses, then `done`=1 and `busy`=0 until the next `load` or `reset`.
  - The reload register still exists but is only written, never read.

## Test plan
- Reset and hold:
  - Stimulus: `reset`=1 for 2 cycles, then `enable`=1 with no `load` for 5 cycles.
  - Required: `Q`=0, `zero`=1, `busy`=0, `done`=0, `tc`=0 throughout.
- One-shot count (macro undefined):
  - Stimulus: `load` with `Din`=5, then `enable`=1.
  - Required: `Q` goes 5,4,3,2,1,0; `tc`=1 for exactly the cycle `Q` first reads 0, which is 5 edges after the load.
  - Then `done`=1 and `Q` holds at 0 for 10 further cycles.
- Pause:
  - Stimulus: `load` with `Din`=3; `enable` pattern 1,0,0,1,1.
  - Required: `Q` goes 3,2,2,2,1,0; `tc` after the 5th edge.
- Reload (macro defined):
  - Stimulus: `load` with `Din`=3, then `enable`=1 for 12 cycles.
  - Required: `tc` pulses every 3rd cycle, 4 pulses in total.
  - `Q` cycles 3,2,1,3,2,1,…; `done` stays 0.
- Collisions:
  - Stimulus: `load` with `Din`=9 asserted on the expiry edge of a count loaded with 2.
  - Required: `tc`=0 and `Q`=9.
  - Stimulus: `reset` asserted when `Q`=4 in RUN.
  - Required: `Q`=0, state IDLE, `tc`=0.
- Edge values:
  - Stimulus: `load` with `Din`=0.
  - Required: `done`=1, no `tc`.
  - Stimulus: `load` with `Din`=15 (WIDTH=4).
  - Required: `tc` exactly 15 enabled edges later.
